// File: rtl/toggle_rx_pkg.sv
// Shared types and default sizes for the toggle event receiver.
// Used by the top and any lab block wanting the same encodings.
package toggle_rx_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;
  localparam int PEND_W_DEF      = 4;

endpackage

// File: rtl/sync_ff.sv
// N-flop level synchroniser, async active-low reset to 0.
// Reusable by other lab blocks.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r <= '0;
    else       r <= {r[STAGES-2:0], d};
  end

  assign q = r[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-line event receiver: sync, edge detect, pending queue count,
// wrapping total and sticky overflow.
module toggle_event_rx
  import toggle_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int PEND_W      = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tog_in,
  input  logic              clr,
  input  logic              evt_ready,
  output logic              evt_pulse,
  output logic              evt_valid,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overflow
);

  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);

  logic      synced;
  rx_state_t state_q, state_d;
  logic      ref_q, ref_d;
  logic      pulse_d;
  logic [IW-1:0] init_q, init_d;
  logic      pop;
  logic      pend_full;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (tog_in),
    .q    (synced)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_INIT;
      ref_q     <= 1'b0;
      init_q    <= '0;
      evt_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      init_q    <= init_d;
      evt_pulse <= pulse_d;
    end
  end

  // INIT tracks the line until the reset-zeroed chain has filled,
  // so a line already high at release is never seen as an event.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    init_d  = init_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        ref_d  = synced;
        init_d = init_q + 1'b1;
        if (init_q == INIT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        pulse_d = synced ^ ref_q;
        ref_d   = synced;
      end
    endcase
  end

  assign evt_valid = |pending;
  assign pop       = evt_valid & evt_ready;
  assign pend_full = &pending;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending   <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      pending   <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (evt_pulse) evt_count <= evt_count + 1'b1;
      unique case (1'b1)
        evt_pulse & ~pop: begin
          if (pend_full) overflow <= 1'b1;
          else           pending  <= pending + 1'b1;
        end
        ~evt_pulse & pop: pending <= pending - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Randomised scoreboard bench for toggle_event_rx.
// Expected pulses are queued by the driver; a monitor pops and compares.
module tb_toggle_event_rx;

  localparam int PEND_W = 4;
  localparam int CNT_W  = 8;
  localparam int PMAX   = (1 << PEND_W) - 1;
  localparam int CMOD   = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              tog_in = 1'b1;
  logic              clr = 1'b0;
  logic              evt_ready = 1'b0;
  logic              evt_pulse;
  logic              evt_valid;
  logic [PEND_W-1:0] pending;
  logic [CNT_W-1:0]  evt_count;
  logic              overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];
  bit mon_en = 1'b0;

  int m_pend = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_pulse_prev = 1'b0;

  toggle_event_rx #(
    .SYNC_STAGES (2),
    .CNT_W       (CNT_W),
    .PEND_W      (PEND_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tog_in    (tog_in),
    .clr       (clr),
    .evt_ready (evt_ready),
    .evt_pulse (evt_pulse),
    .evt_valid (evt_valid),
    .pending   (pending),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pend = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_pulse_prev = 1'b0;
  endtask

  // Monitor: reference model advances one clock and is compared.
  always @(posedge clk) begin
    bit pop;
    bit exp_p;
    cyc++;
    #1;
    if (mon_en) begin
      if (clr) begin
        m_pend = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
      end else begin
        if (m_pulse_prev) m_cnt = (m_cnt + 1) % CMOD;
        pop = (m_pend != 0) && evt_ready;
        if (m_pulse_prev && !pop) begin
          if (m_pend == PMAX) m_ovf = 1'b1;
          else m_pend++;
        end else if (!m_pulse_prev && pop) begin
          m_pend--;
        end
      end
      exp_p = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (exp_p) void'(exp_q.pop_front());
      chk("evt_pulse", int'(evt_pulse), int'(exp_p));
      chk("pending", int'(pending), m_pend);
      chk("evt_valid", int'(evt_valid), int'(m_pend != 0));
      chk("evt_count", int'(evt_count), m_cnt);
      chk("overflow", int'(overflow), int'(m_ovf));
      m_pulse_prev = exp_p;
    end
  end

  // One driven cycle; a toggle applied before edge e pulses after edge e+2.
  task automatic drive(bit t, bit r, bit c);
    @(negedge clk);
    if (t) begin
      tog_in = ~tog_in;
      exp_q.push_back(cyc + 3);
    end
    evt_ready = r;
    clr = c;
  endtask

  function automatic bit rdy(int mode);
    if (mode == 2) return bit'($urandom_range(0, 1));
    return bit'(mode);
  endfunction

  task automatic idle(int n, int mode);
    repeat (n) drive(1'b0, rdy(mode), 1'b0);
  endtask

  task automatic toggles(int n, int mode, int gmin, int gmax);
    repeat (n) begin
      drive(1'b1, rdy(mode), 1'b0);
      idle($urandom_range(gmin, gmax), mode);
    end
  endtask

  initial begin
    // 1: line high through reset is absorbed by INIT
    model_clear();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(10, 0);
    chk("t1_count", int'(evt_count), 0);

    // 2: single toggle
    drive(1'b1, 1'b0, 1'b0);
    idle(5, 0);
    chk("t2_pending", int'(pending), 1);
    chk("t2_valid", int'(evt_valid), 1);
    chk("t2_count", int'(evt_count), 1);

    // 3: queue five, then drain
    idle(3, 1);
    toggles(5, 0, 5, 5);
    chk("t3_pending", int'(pending), 5);
    chk("t3_count", int'(evt_count), 6);
    idle(5, 1);
    idle(1, 0);
    chk("t3_drained", int'(pending), 0);
    chk("t3_valid", int'(evt_valid), 0);

    // 4: overflow, then pulse+pop at full
    drive(1'b0, 1'b0, 1'b1);
    toggles(16, 0, 3, 6);
    chk("t4_pending", int'(pending), 15);
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_count", int'(evt_count), 16);
    drive(1'b1, 1'b0, 1'b0);
    idle(2, 0);
    drive(1'b0, 1'b1, 1'b0);
    idle(3, 0);
    chk("t4_full_pop", int'(pending), 15);
    chk("t4_count2", int'(evt_count), 17);

    // 5: wrap with random consumer, clr, clr on pulse
    drive(1'b0, 1'b0, 1'b1);
    toggles(257, 2, 3, 6);
    chk("t5_wrap", int'(evt_count), 1);
    drive(1'b0, 1'b0, 1'b1);
    idle(1, 0);
    chk("t5_clr_pend", int'(pending), 0);
    chk("t5_clr_cnt", int'(evt_count), 0);
    chk("t5_clr_ovf", int'(overflow), 0);
    drive(1'b1, 1'b0, 1'b0);
    idle(2, 0);
    drive(1'b0, 1'b0, 1'b1);
    idle(3, 0);
    chk("t5_clr_pulse", int'(evt_count), 0);
    chk("t5_clr_pend2", int'(pending), 0);

    // 6: async reset mid-burst
    toggles(3, 0, 4, 4);
    chk("t6_pre", int'(pending), 3);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk("t6_pulse", int'(evt_pulse), 0);
    chk("t6_valid", int'(evt_valid), 0);
    chk("t6_pend", int'(pending), 0);
    chk("t6_cnt", int'(evt_count), 0);
    chk("t6_ovf", int'(overflow), 0);
    model_clear();
    tog_in = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    idle(10, 0);
    chk("t6_no_evt", int'(evt_count), 0);

    // random tail: mixed gaps and consumer
    toggles(40, 2, 3, 9);
    idle(6, 2);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
